// File: rtl/bricks_map_renderer.sv
// Brick layer of the pixel pipeline: maps the draw coordinate to a sprite ROM
// palette index and a brick-present flag, and owns the 1-bit brick occupancy map.
module bricks_map_renderer #(
    parameter int TILE_LOG2 = 4,
    parameter int MAP_W     = 40,
    parameter int MAP_H     = 30
) (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic [9:0] DrawX,
    input  logic [9:0] DrawY,
    input  logic       pix_valid,
    input  logic       map_we,
    input  logic [5:0] map_wx,
    input  logic [4:0] map_wy,
    input  logic       map_wdata,
    input  logic       level_load,
    input  logic [5:0] q_x,
    input  logic [4:0] q_y,
    output logic       q_hit,
    output logic [7:0] rom_addr,
    input  logic [7:0] rom_data,
    output logic [7:0] pixel_index,
    output logic       brick_on,
    output logic       pix_out_valid,
    output logic       busy
);
    localparam int CELLS = MAP_W * MAP_H;
    localparam int IDX_W = $clog2(CELLS);

    typedef enum logic {ST_INIT, ST_IDLE} state_t;

    state_t           state, state_nxt;
    logic [IDX_W-1:0] init_idx;
    logic [5:0]       init_col;
    logic [4:0]       init_row;
    logic [CELLS-1:0] map_bits;

    logic [9:0]       px_col, px_row;
    logic [IDX_W-1:0] px_idx, q_idx, w_idx;
    logic             px_in, q_in, w_in;
    logic             idle, init_last, wr_ok, border;
    logic             cell_p0, vld_p0, cell_p1, vld_p1;

    function automatic logic [IDX_W-1:0] cell_index(input logic [9:0] col, input logic [9:0] row);
        return IDX_W'(row) * IDX_W'(MAP_W) + IDX_W'(col);
    endfunction

    function automatic logic in_map(input logic [9:0] col, input logic [9:0] row);
        return (int'(col) < MAP_W) && (int'(row) < MAP_H);
    endfunction

    assign px_col = DrawX >> TILE_LOG2;
    assign px_row = DrawY >> TILE_LOG2;
    assign px_idx = cell_index(px_col, px_row);
    assign px_in  = in_map(px_col, px_row);
    assign q_idx  = cell_index({4'd0, q_x}, {5'd0, q_y});
    assign q_in   = in_map({4'd0, q_x}, {5'd0, q_y});
    assign w_idx  = cell_index({4'd0, map_wx}, {5'd0, map_wy});
    assign w_in   = in_map({4'd0, map_wx}, {5'd0, map_wy});

    assign idle      = (state == ST_IDLE);
    assign busy      = (state == ST_INIT);
    assign init_last = (init_idx == IDX_W'(CELLS - 1));
    assign border    = (init_col == 6'd0) || (int'(init_col) == MAP_W - 1) ||
                       (init_row == 5'd0) || (int'(init_row) == MAP_H - 1);

    always_comb begin
        state_nxt = state;
        wr_ok     = 1'b0;
        case (state)
            ST_INIT: if (init_last) state_nxt = ST_IDLE;
            ST_IDLE: begin
                // A rebuild request takes priority over a coincident game write.
                if (level_load) state_nxt = ST_INIT;
                else            wr_ok = map_we && w_in;
            end
            default: state_nxt = ST_INIT;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state    <= ST_INIT;
            init_idx <= '0;
            init_col <= '0;
            init_row <= '0;
        end else begin
            state <= state_nxt;
            if (state == ST_INIT) begin
                if (init_last) begin
                    init_idx <= '0;
                    init_col <= '0;
                    init_row <= '0;
                end else begin
                    init_idx <= init_idx + IDX_W'(1);
                    if (int'(init_col) == MAP_W - 1) begin
                        init_col <= '0;
                        init_row <= init_row + 5'd1;
                    end else begin
                        init_col <= init_col + 6'd1;
                    end
                end
            end
        end
    end

    // Map storage is fully rewritten by the init sweep, so it carries no reset.
    always_ff @(posedge Clk) begin
        if (state == ST_INIT) map_bits[init_idx] <= border;
        else if (wr_ok)       map_bits[w_idx]    <= map_wdata;
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            cell_p0       <= 1'b0;
            vld_p0        <= 1'b0;
            rom_addr      <= '0;
            q_hit         <= 1'b0;
            cell_p1       <= 1'b0;
            vld_p1        <= 1'b0;
            pixel_index   <= '0;
            brick_on      <= 1'b0;
            pix_out_valid <= 1'b0;
        end else begin
            // p0: cell lookup and sprite ROM address
            cell_p0  <= idle && px_in && pix_valid && map_bits[px_idx];
            vld_p0   <= pix_valid;
            rom_addr <= {DrawY[3:0], DrawX[3:0]};
            q_hit    <= idle && q_in && map_bits[q_idx];
            // p1: wait for the ROM read
            cell_p1  <= cell_p0;
            vld_p1   <= vld_p0;
            // p2: outputs aligned with rom_data
            pixel_index   <= rom_data;
            brick_on      <= cell_p1;
            pix_out_valid <= vld_p1;
        end
    end
endmodule

// File: tb/tb_bricks_map_renderer.sv
// Self-checking bench for bricks_map_renderer: an array-based model of the brick
// map predicts pixel, query and init behaviour under directed and random stimulus.
module tb_bricks_map_renderer;
    localparam int N = 400;

    logic       Clk = 1'b0;
    logic       Reset_n = 1'b0;
    logic [9:0] DrawX = '0, DrawY = '0;
    logic       pix_valid = 1'b0, map_we = 1'b0, map_wdata = 1'b0, level_load = 1'b0;
    logic [5:0] map_wx = '0, q_x = '0;
    logic [4:0] map_wy = '0, q_y = '0;
    logic [7:0] rom_data = '0;
    logic       q_hit, brick_on, pix_out_valid, busy;
    logic [7:0] rom_addr, pixel_index;

    int checks = 0;
    int errors = 0;

    bit         ref_map [0:63][0:63];
    logic [7:0] e_addr [0:N-1];
    bit         e_brick [0:N-1];
    bit         e_vld [0:N-1];
    bit         e_q [0:N-1];

    bricks_map_renderer dut (
        .Clk(Clk), .Reset_n(Reset_n), .DrawX(DrawX), .DrawY(DrawY), .pix_valid(pix_valid),
        .map_we(map_we), .map_wx(map_wx), .map_wy(map_wy), .map_wdata(map_wdata),
        .level_load(level_load), .q_x(q_x), .q_y(q_y), .q_hit(q_hit), .rom_addr(rom_addr),
        .rom_data(rom_data), .pixel_index(pixel_index), .brick_on(brick_on),
        .pix_out_valid(pix_out_valid), .busy(busy)
    );

    always #5 Clk = ~Clk;

    // Synchronous sprite ROM whose content equals its address.
    always @(posedge Clk) rom_data <= rom_addr;

    function automatic void model_rebuild();
        for (int r = 0; r < 64; r++)
            for (int c = 0; c < 64; c++)
                ref_map[r][c] = (r < 30 && c < 40) && (r == 0 || c == 0 || r == 29 || c == 39);
    endfunction

    function automatic bit model_cell(input int col, input int row);
        return (col < 40 && row < 30) ? ref_map[row][col] : 1'b0;
    endfunction

    function automatic bit model_brick(input logic [9:0] x, input logic [9:0] y, input bit v);
        return v && model_cell(int'(x) / 16, int'(y) / 16);
    endfunction

    function automatic void model_write(input int col, input int row, input bit d);
        if (col < 40 && row < 30) ref_map[row][col] = d;
    endfunction

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic test_reset();
        int n;
        Reset_n = 1'b0;
        repeat (3) tick();
        checks++; if (q_hit !== 1'b0) begin errors++; $display("FAIL reset_q_hit: got %b expected 0", q_hit); end
        checks++; if (rom_addr !== 8'h00) begin errors++; $display("FAIL reset_rom_addr: got %h expected 00", rom_addr); end
        checks++; if (pixel_index !== 8'h00) begin errors++; $display("FAIL reset_pixel_index: got %h expected 00", pixel_index); end
        checks++; if (brick_on !== 1'b0) begin errors++; $display("FAIL reset_brick_on: got %b expected 0", brick_on); end
        checks++; if (pix_out_valid !== 1'b0) begin errors++; $display("FAIL reset_pix_out_valid: got %b expected 0", pix_out_valid); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL reset_busy: got %b expected 1", busy); end
        Reset_n = 1'b1;
        model_rebuild();
        n = 0;
        while (busy === 1'b1 && n < 3000) begin
            n++;
            tick();
        end
        checks++; if (n != 1200) begin errors++; $display("FAIL init_busy_cycles: got %0d expected 1200", n); end
    endtask

    task automatic test_query_init();
        int qxs [4] = '{0, 5, 39, 40};
        int qys [4] = '{0, 5, 29, 0};
        bit qe  [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 4; i++) begin
            q_x = 6'(qxs[i]); q_y = 5'(qys[i]);
            tick();
            checks++; if (q_hit !== qe[i]) begin errors++; $display("FAIL query_init(%0d,%0d): got %b expected %b", qxs[i], qys[i], q_hit, qe[i]); end
        end
        for (int i = 0; i < 16; i++) begin
            q_x = 6'($urandom_range(47)); q_y = 5'($urandom_range(31));
            tick();
            checks++; if (q_hit !== model_cell(int'(q_x), int'(q_y))) begin errors++; $display("FAIL query_rand(%0d,%0d): got %b expected %b", q_x, q_y, q_hit, model_cell(int'(q_x), int'(q_y))); end
        end
    endtask

    task automatic test_pixel_basic();
        DrawX = 10'd20; DrawY = 10'd3; pix_valid = 1'b1;
        tick();
        pix_valid = 1'b0;
        checks++; if (rom_addr !== 8'h34) begin errors++; $display("FAIL pixel_rom_addr: got %h expected 34", rom_addr); end
        tick();
        tick();
        checks++; if (pixel_index !== 8'h34) begin errors++; $display("FAIL pixel_index: got %h expected 34", pixel_index); end
        checks++; if (brick_on !== 1'b1) begin errors++; $display("FAIL pixel_brick_on: got %b expected 1", brick_on); end
        checks++; if (pix_out_valid !== 1'b1) begin errors++; $display("FAIL pixel_out_valid: got %b expected 1", pix_out_valid); end
    endtask

    task automatic test_write_clear();
        map_we = 1'b1; map_wx = 6'd1; map_wy = 5'd0; map_wdata = 1'b0;
        tick();
        map_we = 1'b0;
        model_write(1, 0, 1'b0);
        DrawY = 10'd0;
        for (int i = 0; i < 19; i++) begin
            if (i >= 3) begin
                checks++; if (brick_on !== 1'b0) begin errors++; $display("FAIL cleared_brick_x%0d: got %b expected 0", 13 + i, brick_on); end
            end
            pix_valid = (i < 16);
            DrawX = 10'(16 + i);
            tick();
        end
        pix_valid = 1'b0;
        q_x = 6'd1; q_y = 5'd0;
        tick();
        checks++; if (q_hit !== 1'b0) begin errors++; $display("FAIL cleared_query: got %b expected 0", q_hit); end
    endtask

    task automatic test_same_cycle();
        map_we = 1'b1; map_wx = 6'd3; map_wy = 5'd3; map_wdata = 1'b1;
        q_x = 6'd3; q_y = 5'd3;
        tick();
        map_we = 1'b0;
        model_write(3, 3, 1'b1);
        checks++; if (q_hit !== 1'b0) begin errors++; $display("FAIL same_cycle_old: got %b expected 0", q_hit); end
        tick();
        checks++; if (q_hit !== 1'b1) begin errors++; $display("FAIL same_cycle_new: got %b expected 1", q_hit); end
    endtask

    task automatic test_back_to_back();
        logic [9:0] x, y;
        bit v;
        for (int i = 0; i < N + 3; i++) begin
            if (i >= 1 && i <= N) begin
                checks++; if (rom_addr !== e_addr[i-1]) begin errors++; $display("FAIL b2b_rom_addr[%0d]: got %h expected %h", i - 1, rom_addr, e_addr[i-1]); end
                checks++; if (q_hit !== e_q[i-1]) begin errors++; $display("FAIL b2b_q_hit[%0d]: got %b expected %b", i - 1, q_hit, e_q[i-1]); end
            end
            if (i >= 3) begin
                checks++; if (pixel_index !== e_addr[i-3]) begin errors++; $display("FAIL b2b_pixel_index[%0d]: got %h expected %h", i - 3, pixel_index, e_addr[i-3]); end
                checks++; if (brick_on !== e_brick[i-3]) begin errors++; $display("FAIL b2b_brick_on[%0d]: got %b expected %b", i - 3, brick_on, e_brick[i-3]); end
                checks++; if (pix_out_valid !== e_vld[i-3]) begin errors++; $display("FAIL b2b_pix_out_valid[%0d]: got %b expected %b", i - 3, pix_out_valid, e_vld[i-3]); end
            end
            if (i < N) begin
                x = ($urandom_range(3) == 0) ? 10'($urandom_range(1023)) : 10'($urandom_range(639));
                y = ($urandom_range(3) == 0) ? 10'($urandom_range(1023)) : 10'($urandom_range(479));
                v = ($urandom_range(3) != 0);
                DrawX = x; DrawY = y; pix_valid = v;
                q_x = 6'($urandom_range(47)); q_y = 5'($urandom_range(31));
                e_addr[i]  = {y[3:0], x[3:0]};
                e_brick[i] = model_brick(x, y, v);
                e_vld[i]   = v;
                e_q[i]     = model_cell(int'(q_x), int'(q_y));
                map_we    = ($urandom_range(2) == 0);
                map_wdata = 1'($urandom_range(1));
                case ($urandom_range(3))
                    0:       begin map_wx = q_x;           map_wy = q_y;           end
                    1:       begin map_wx = 6'(x / 16);    map_wy = 5'(y / 16);    end
                    default: begin map_wx = 6'($urandom_range(45)); map_wy = 5'($urandom_range(31)); end
                endcase
                if (map_we) model_write(int'(map_wx), int'(map_wy), map_wdata);
            end else begin
                pix_valid = 1'b0;
                map_we = 1'b0;
            end
            tick();
        end
    endtask

    task automatic test_level_load();
        int n;
        map_we = 1'b1; map_wx = 6'd3; map_wy = 5'd3; map_wdata = 1'b1;
        tick();
        model_write(3, 3, 1'b1);
        level_load = 1'b1; map_wx = 6'd5; map_wy = 5'd5; map_wdata = 1'b1;
        tick();
        level_load = 1'b0;
        model_rebuild();
        DrawX = 10'd0; DrawY = 10'd0; pix_valid = 1'b1;
        n = 0;
        while (busy === 1'b1 && n < 3000) begin
            n++;
            if (n >= 10 && n <= 1100) begin
                checks++; if (brick_on !== 1'b0) begin errors++; $display("FAIL busy_brick_on@%0d: got %b expected 0", n, brick_on); end
            end
            map_we = 1'b1;
            map_wx = 6'($urandom_range(39)); map_wy = 5'($urandom_range(29)); map_wdata = 1'($urandom_range(1));
            level_load = (n == 300);
            tick();
        end
        map_we = 1'b0; level_load = 1'b0; pix_valid = 1'b0;
        checks++; if (n != 1200) begin errors++; $display("FAIL reload_busy_cycles: got %0d expected 1200", n); end
        for (int r = 0; r < 30; r++) begin
            for (int c = 0; c < 40; c++) begin
                q_x = 6'(c); q_y = 5'(r);
                tick();
                checks++; if (q_hit !== model_cell(c, r)) begin errors++; $display("FAIL reload_map(%0d,%0d): got %b expected %b", c, r, q_hit, model_cell(c, r)); end
            end
        end
    endtask

    task automatic test_reset_mid_init();
        int n;
        level_load = 1'b1;
        tick();
        level_load = 1'b0;
        DrawX = 10'd37; DrawY = 10'd26; pix_valid = 1'b1;
        repeat (600) tick();
        checks++; if (pix_out_valid !== 1'b1) begin errors++; $display("FAIL pre_reset_valid: got %b expected 1", pix_out_valid); end
        Reset_n = 1'b0;
        #1;
        checks++; if (rom_addr !== 8'h00) begin errors++; $display("FAIL midreset_rom_addr: got %h expected 00", rom_addr); end
        checks++; if (pixel_index !== 8'h00) begin errors++; $display("FAIL midreset_pixel_index: got %h expected 00", pixel_index); end
        checks++; if (pix_out_valid !== 1'b0) begin errors++; $display("FAIL midreset_pix_out_valid: got %b expected 0", pix_out_valid); end
        checks++; if (brick_on !== 1'b0) begin errors++; $display("FAIL midreset_brick_on: got %b expected 0", brick_on); end
        checks++; if (q_hit !== 1'b0) begin errors++; $display("FAIL midreset_q_hit: got %b expected 0", q_hit); end
        pix_valid = 1'b0;
        tick();
        tick();
        Reset_n = 1'b1;
        model_rebuild();
        n = 0;
        while (busy === 1'b1 && n < 3000) begin
            n++;
            tick();
        end
        checks++; if (n != 1200) begin errors++; $display("FAIL restart_busy_cycles: got %0d expected 1200", n); end
    endtask

    task automatic test_pix_valid_low();
        DrawX = 10'd0; DrawY = 10'd0; pix_valid = 1'b0;
        repeat (3) tick();
        checks++; if (pix_out_valid !== 1'b0) begin errors++; $display("FAIL invalid_pix_out_valid: got %b expected 0", pix_out_valid); end
        checks++; if (brick_on !== 1'b0) begin errors++; $display("FAIL invalid_brick_on: got %b expected 0", brick_on); end
        pix_valid = 1'b1;
        repeat (3) tick();
        pix_valid = 1'b0;
        checks++; if (pix_out_valid !== 1'b1) begin errors++; $display("FAIL valid_pix_out_valid: got %b expected 1", pix_out_valid); end
        checks++; if (brick_on !== model_brick(10'd0, 10'd0, 1'b1)) begin errors++; $display("FAIL valid_brick_on: got %b expected %b", brick_on, model_brick(10'd0, 10'd0, 1'b1)); end
    endtask

    initial begin
        test_reset();
        test_query_init();
        test_pixel_basic();
        test_write_clear();
        test_same_cycle();
        test_back_to_back();
        test_level_load();
        test_reset_mid_init();
        test_pix_valid_low();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/bricks_map_renderer.md
Name: bricks_map_renderer

Overview:
- Pixel-pipeline stage directly upstream of the 256-entry brick palette lookup. Per pixel, turns the VGA draw coordinate into an 8-bit palette index plus a brick-present flag.
- Holds a 1-bit-per-cell brick occupancy map that game logic can clear or set when bricks are hit or rebuilt, and a registered collision query port for tank/bullet logic.
- Drives an external synchronous brick sprite ROM that returns palette indices.

Parameters:
- TILE_LOG2, 4, log2 tile edge in pixels (16x16 tiles; tile pixel offset = 8 bits = ROM address).
- MAP_W, 40, map width in tiles.
- MAP_H, 30, map height in tiles.

Ports:
- Clk  in  1  system clock; all state rises on posedge.
- Reset_n  in  1  asynchronous, active-low reset.
- DrawX  in  10  current pixel column.
- DrawY  in  10  current pixel row.
- pix_valid  in  1  DrawX/DrawY is an active-video pixel.
- map_we  in  1  single-cycle map write strobe.
- map_wx  in  6  write cell column.
- map_wy  in  5  write cell row.
- map_wdata  in  1  1 = brick present, 0 = cleared.
- level_load  in  1  pulse: rebuild the default map.
- q_x  in  6  query cell column.
- q_y  in  5  query cell row.
- q_hit  out  1  registered: queried cell holds a brick.
- rom_addr  out  8  sprite ROM address {DrawY[3:0], DrawX[3:0]}, registered.
- rom_data  in  8  sprite ROM output, valid 1 cycle after rom_addr.
- pixel_index  out  8  palette index for the palette stage.
- brick_on  out  1  pixel_index is a brick pixel.
- pix_out_valid  out  1  pix_valid delayed to align with pixel_index.
- busy  out  1  map initialisation in progress.

Behaviour:
- Reset (async, Reset_n=0): pipeline regs, pixel_index, brick_on, pix_out_valid, q_hit, rom_addr = 0. FSM enters INIT with cell counter 0, so busy=1 on the first cycle after release.
- Pixel pipeline, fixed latency 3:
  - Cycle n: DrawX/DrawY/pix_valid sampled.
  - Cycle n+1: cell bit registered; rom_addr driven.
  - Cycle n+2: rom_data valid.
  - Cycle n+3: pixel_index = rom_data, brick_on = cell bit AND in-range AND pix_valid AND NOT busy, pix_out_valid = delayed pix_valid.
  - The pipeline advances every cycle with no stalls.
- Cell = (DrawX>>TILE_LOG2, DrawY>>TILE_LOG2). Cell is out of range if column ≥ MAP_W or row ≥ MAP_H; then brick_on = 0, pixel_index still = rom_data.
- Map write: when map_we=1, FSM in IDLE and cell in range, cell ← map_wdata at the clock edge. Otherwise the write is dropped silently.
- Query: q_hit(n+1) = map[q_y][q_x] sampled at n. Out-of-range query returns 0; returns 0 while busy.
- Same-cycle write and read (pixel or query) of the same cell returns the old value.
- FSM states:
  - INIT: each cycle writes cell[counter] = 1 if the cell is on the border (col 0, col MAP_W-1, row 0 or row MAP_H-1), else 0. Counter increments row-major; after cell MAP_W*MAP_H-1 (cycle 1199 at defaults) → IDLE, and busy=0 from the next cycle.
  - IDLE: level_load=1 → INIT with counter 0. If level_load and map_we coincide, level_load wins and the write is dropped.
  - level_load during INIT is ignored; the sweep does not restart.
- Reset mid-INIT restarts the sweep from cell 0.

Test Plan:
- Reset, release, count cycles: busy high exactly 1200 cycles. Then query (0,0) → q_hit=1, (5,5) → 0, (39,29) → 1, (40,0) → 0.
- After init, drive DrawX=20, DrawY=3, pix_valid=1 → rom_addr=0x34 one cycle later. ROM model returns 0x34 → at n+3 pixel_index=0x34, brick_on=1, pix_out_valid=1.
- Write map_wx=1, map_wy=0, map_wdata=0. Then DrawX=16..31, DrawY=0 → brick_on=0 for those 16 pixels; query (1,0) → 0.
- Same cycle: map_we set (3,3)=1 and q=(3,3) → q_hit=0. Next-cycle query → 1.
- Write (3,3)=1, pulse level_load in IDLE → busy=1 for 1200 cycles; afterwards query (3,3) → 0. Map writes during busy leave the map unchanged.
- Assert Reset_n=0 at cycle 600 of INIT → all outputs 0 immediately. After release, busy lasts a full 1200 cycles. pix_valid=0 input → pix_out_valid=0 and brick_on=0 three cycles later.
